color_to_gray: RTL

Pipelined RGB-to-grayscale decoder: the inverse of `gray_to_color`. It accepts one 24-bit RGB pixel per clock and returns an 8-bit gray value. In JET mode it exactly inverts the JET colormap and flags pixels that do not lie on the JET curve. In the other modes it computes luminance or max-channel gray. It sits at the front of the colorized-image ingest path and drives the existing gray-domain filters.

---
 rtl/color_to_gray.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/color_to_gray.sv
// -----------------------------------------------------------------------------
// color_to_gray
// Pipelined RGB-to-grayscale decoder. It accepts one 24-bit pixel per clock and
// returns one 8-bit gray value per accepted pixel, four edges later.
//   mode 00 : exact inverse of the JET colormap, with an off-curve flag
//             (falls back to luminance when the pixel is off the curve)
//   mode 01 : luminance (77r + 150g + 29b) >> 8
//   mode 10 : max(r, g, b)
//   mode 11 : luminance
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   r_in/g_in/b_in  input pixel channels
//   data_valid      input pixel qualifier
//   mode_sel        decode mode, travels with its pixel
//   clr_err         synchronous clear of err_count (wins over an increment)
//   gray_out        decoded gray, held while data_out_valid is low
//   data_out_valid  one pulse per accepted pixel
//   match_err       JET mode only: pixel not on the JET curve
//   err_count       saturating count of match_err pulses
// -----------------------------------------------------------------------------
module color_to_gray #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       r_in,
  input  logic [7:0]       g_in,
  input  logic [7:0]       b_in,
  input  logic             data_valid,
  input  logic [1:0]       mode_sel,
  input  logic             clr_err,
  output logic [7:0]       gray_out,
  output logic             data_out_valid,
  output logic             match_err,
  output logic [ERR_W-1:0] err_count
);

  // ---------------------------------------------------------------------------
  // Stage 1: input capture
  // ---------------------------------------------------------------------------
  logic [7:0] r_s1_r, r_s1_g, r_s1_b;
  logic [1:0] r_s1_mode;
  logic       r_s1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_r     <= '0;
      r_s1_g     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= data_valid;
      if (data_valid) begin
        r_s1_r    <= r_in;
        r_s1_g    <= g_in;
        r_s1_b    <= b_in;
        r_s1_mode <= mode_sel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // JET segment match on the stage-1 pixel, first match wins (S2, S0, S1, S3).
  // S2 is checked first so that (0,255,255) decodes to 128; its r<=252 bound
  // leaves (255,255,0) to S3, which decodes it to 192.
  // ---------------------------------------------------------------------------
  logic       w_seg0, w_seg1, w_seg2, w_seg3;
  logic       w_jet_hit;
  logic [7:0] w_jet_gray;

  assign w_seg2 = (r_s1_g == 8'd255) && (r_s1_r <= 8'd252) &&
                  (r_s1_r[1:0] == 2'b00) && (r_s1_b == (8'd255 - r_s1_r));
  assign w_seg0 = (r_s1_r == 8'd0) && (r_s1_g == 8'd0) && (r_s1_b[1:0] == 2'b00);
  assign w_seg1 = (r_s1_r == 8'd0) && (r_s1_b == 8'd255) && (r_s1_g[1:0] == 2'b00);
  assign w_seg3 = (r_s1_r == 8'd255) && (r_s1_b == 8'd0) && (r_s1_g[1:0] == 2'b11);
  assign w_jet_hit = w_seg0 | w_seg1 | w_seg2 | w_seg3;

  always_comb begin
    w_jet_gray = 8'd0;
    if (w_seg2)      w_jet_gray = 8'd128 + {2'b00, r_s1_r[7:2]};
    else if (w_seg0) w_jet_gray = {2'b00, r_s1_b[7:2]};
    else if (w_seg1) w_jet_gray = 8'd64 + {2'b00, r_s1_g[7:2]};
    else if (w_seg3) w_jet_gray = 8'd192 + 8'((8'd255 - r_s1_g) >> 2);
  end

  // ---------------------------------------------------------------------------
  // Stage 2a: weighted channel products, partial max, JET decision.
  // The luminance multiply and the three-way add are split across two
  // registers to keep the multiplier-adder path short.
  // ---------------------------------------------------------------------------
  logic [15:0] r_s2a_pr, r_s2a_pg, r_s2a_pb;
  logic [7:0]  r_s2a_max_rg, r_s2a_b;
  logic        r_s2a_hit;
  logic [7:0]  r_s2a_jet;
  logic [1:0]  r_s2a_mode;
  logic        r_s2a_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2a_pr     <= '0;
      r_s2a_pg     <= '0;
      r_s2a_pb     <= '0;
      r_s2a_max_rg <= '0;
      r_s2a_b      <= '0;
      r_s2a_hit    <= 1'b0;
      r_s2a_jet    <= '0;
      r_s2a_mode   <= '0;
      r_s2a_valid  <= 1'b0;
    end else begin
      r_s2a_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2a_pr     <= {8'd0, r_s1_r} * 16'd77;
        r_s2a_pg     <= {8'd0, r_s1_g} * 16'd150;
        r_s2a_pb     <= {8'd0, r_s1_b} * 16'd29;
        r_s2a_max_rg <= (r_s1_r > r_s1_g) ? r_s1_r : r_s1_g;
        r_s2a_b      <= r_s1_b;
        r_s2a_hit    <= w_jet_hit;
        r_s2a_jet    <= w_jet_gray;
        r_s2a_mode   <= r_s1_mode;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2b: luminance sum (max 65280, fits in 16 bits) and full max
  // ---------------------------------------------------------------------------
  logic [7:0] r_s2b_lum, r_s2b_max, r_s2b_jet;
  logic       r_s2b_hit;
  logic [1:0] r_s2b_mode;
  logic       r_s2b_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2b_lum   <= '0;
      r_s2b_max   <= '0;
      r_s2b_jet   <= '0;
      r_s2b_hit   <= 1'b0;
      r_s2b_mode  <= '0;
      r_s2b_valid <= 1'b0;
    end else begin
      r_s2b_valid <= r_s2a_valid;
      if (r_s2a_valid) begin
        r_s2b_lum  <= 8'((r_s2a_pr + r_s2a_pg + r_s2a_pb) >> 8);
        r_s2b_max  <= (r_s2a_max_rg > r_s2a_b) ? r_s2a_max_rg : r_s2a_b;
        r_s2b_jet  <= r_s2a_jet;
        r_s2b_hit  <= r_s2a_hit;
        r_s2b_mode <= r_s2a_mode;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: result select and output registers
  // ---------------------------------------------------------------------------
  logic [7:0] w_sel_gray;
  logic       w_sel_err;

  always_comb begin
    w_sel_gray = r_s2b_lum;
    w_sel_err  = 1'b0;
    case (r_s2b_mode)
      2'b00: begin
        if (r_s2b_hit) w_sel_gray = r_s2b_jet;
        w_sel_err = ~r_s2b_hit;
      end
      2'b10:   w_sel_gray = r_s2b_max;
      default: w_sel_gray = r_s2b_lum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_out       <= '0;
      data_out_valid <= 1'b0;
      match_err      <= 1'b0;
    end else begin
      data_out_valid <= r_s2b_valid;
      match_err      <= r_s2b_valid & w_sel_err;
      if (r_s2b_valid) gray_out <= w_sel_gray;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (data_out_valid && match_err && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
